// File: rtl/nfa_stream_gen.sv
// rtl/nfa_stream_gen.sv - pattern byte-stream source and match checker for NFA matcher bring-up
//
// Purpose:
//   Drives a matcher chain through its en/payload interface. It emits a
//   3-byte literal pattern a programmed number of times, with filler gaps
//   before each repetition. It counts the match pulses returned by the
//   matcher and flags a miss when the count differs from the expected count.
//
// Ports:
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   start        in   one-cycle run request, sampled only in IDLE
//   repeats      in   CNT_W  pattern repetitions, latched on accepted start
//   gap          in   4      filler bytes before each repetition, latched on start
//   match        in   match pulse from the matcher under test
//   corrupt      in   (NFA_GEN_CORRUPT_EN only) sampled while PAT0 is on the bus;
//                     when set, that repetition carries ~PAT1 in place of PAT1
//   en           out  payload-valid strobe
//   payload      out  8      byte to the matcher
//   busy         out  high from the cycle after an accepted start until DONE
//   done         out  one-cycle completion pulse
//   match_count  out  CNT_W  matches seen during the run, saturating
//   miss         out  sticky: match_count differed from expected at completion
//
// Build option:
//   NFA_GEN_CORRUPT_EN  adds the corrupt input and the corrupted-repeat
//                       counter; expected = repeats - corrupted repeats.
//
// DRAIN_CYC must be at least 1.

module nfa_stream_gen #(
  parameter logic [7:0] PAT0      = 8'h61,
  parameter logic [7:0] PAT1      = 8'h62,
  parameter logic [7:0] PAT2      = 8'h63,
  parameter logic [7:0] FILL      = 8'h78,
  parameter int         CNT_W     = 8,
  parameter int         DRAIN_CYC = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] repeats,
  input  logic [3:0]       gap,
  input  logic             match,
`ifdef NFA_GEN_CORRUPT_EN
  input  logic             corrupt,
`endif
  output logic             en,
  output logic [7:0]       payload,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_count,
  output logic             miss
);

  // Sub-counter is shared by GAP (up to 15 bytes) and DRAIN.
  localparam int SUB_W = (DRAIN_CYC > 16) ? $clog2(DRAIN_CYC) : 4;
  localparam logic [CNT_W-1:0] MC_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_PAT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] rep_total_q;
  logic [CNT_W-1:0] rep_left_q;
  logic [3:0]       gap_q;
  logic [SUB_W-1:0] sub_q;
  logic [1:0]       idx_q;
  logic             en_q;
  logic [7:0]       payload_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] mc_q;
  logic [CNT_W-1:0] mc_d;
  logic             miss_q;
  logic [CNT_W-1:0] expected_d;

  logic             corrupt_now;
  logic [CNT_W-1:0] corr_cnt;

`ifdef NFA_GEN_CORRUPT_EN
  logic [CNT_W-1:0] corr_q;

  // corrupt is looked at on the edge that ends the PAT0 cycle, which is the
  // same edge that loads the second pattern byte.
  assign corrupt_now = (state_q == S_PAT) && (idx_q == 2'd0) && corrupt;
  assign corr_cnt    = corr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      corr_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      corr_q <= '0;
    end else if (corrupt_now && (corr_q != MC_MAX)) begin
      corr_q <= corr_q + CNT_W'(1);
    end
  end
`else
  assign corrupt_now = 1'b0;
  assign corr_cnt    = '0;
`endif

  // Match pulses count in every non-IDLE state, including the DONE cycle.
  always_comb begin
    mc_d = mc_q;
    if ((state_q != S_IDLE) && match && (mc_q != MC_MAX)) begin
      mc_d = mc_q + CNT_W'(1);
    end
  end

  assign expected_d = rep_total_q - corr_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rep_total_q <= '0;
      rep_left_q  <= '0;
      gap_q       <= '0;
      sub_q       <= '0;
      idx_q       <= '0;
      en_q        <= 1'b0;
      payload_q   <= FILL;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mc_q        <= '0;
      miss_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          en_q      <= 1'b0;
          payload_q <= FILL;
          busy_q    <= 1'b0;
          if (start) begin
            rep_total_q <= repeats;
            rep_left_q  <= repeats;
            gap_q       <= gap;
            mc_q        <= '0;
            miss_q      <= 1'b0;
            idx_q       <= 2'd0;
            if (repeats == '0) begin
              // Empty run: straight to DONE, nothing on the bus, count 0 == expected 0.
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (gap == 4'd0) begin
              state_q   <= S_PAT;
              en_q      <= 1'b1;
              payload_q <= PAT0;
              busy_q    <= 1'b1;
            end else begin
              state_q   <= S_GAP;
              sub_q     <= SUB_W'(gap) - SUB_W'(1);
              en_q      <= 1'b1;
              payload_q <= FILL;
              busy_q    <= 1'b1;
            end
          end
        end

        S_GAP: begin
          mc_q <= mc_d;
          if (sub_q == '0) begin
            state_q   <= S_PAT;
            idx_q     <= 2'd0;
            payload_q <= PAT0;
          end else begin
            sub_q <= sub_q - SUB_W'(1);
          end
        end

        S_PAT: begin
          mc_q <= mc_d;
          case (idx_q)
            2'd0: begin
              idx_q     <= 2'd1;
              payload_q <= corrupt_now ? ~PAT1 : PAT1;
            end
            2'd1: begin
              idx_q     <= 2'd2;
              payload_q <= PAT2;
            end
            default: begin
              // Last pattern byte is on the bus: retire this repetition.
              rep_left_q <= rep_left_q - CNT_W'(1);
              idx_q      <= 2'd0;
              if (rep_left_q != CNT_W'(1)) begin
                if (gap_q == 4'd0) begin
                  payload_q <= PAT0;
                end else begin
                  state_q   <= S_GAP;
                  sub_q     <= SUB_W'(gap_q) - SUB_W'(1);
                  payload_q <= FILL;
                end
              end else begin
                state_q   <= S_DRAIN;
                en_q      <= 1'b0;
                payload_q <= FILL;
                sub_q     <= SUB_W'(DRAIN_CYC - 1);
              end
            end
          endcase
        end

        S_DRAIN: begin
          mc_q <= mc_d;
          if (sub_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            miss_q  <= (mc_d != expected_d);
          end else begin
            sub_q <= sub_q - SUB_W'(1);
          end
        end

        S_DONE: begin
          // A match arriving in the DONE cycle still counts; miss is sticky
          // so it also reflects that final count.
          mc_q    <= mc_d;
          miss_q  <= miss_q | (mc_d != expected_d);
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign en          = en_q;
  assign payload     = payload_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign match_count = mc_q;
  assign miss        = miss_q;

endmodule

// File: tb/tb_nfa_stream_gen.sv
// tb/tb_nfa_stream_gen.sv - scoreboard bench for nfa_stream_gen
`timescale 1ns/1ps
module tb_nfa_stream_gen;

  localparam logic [7:0] PAT0  = 8'h61;
  localparam logic [7:0] PAT1  = 8'h62;
  localparam logic [7:0] PAT2  = 8'h63;
  localparam logic [7:0] FILL  = 8'h78;
  localparam int         DRAIN = 4;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       start   = 1'b0;
  logic [7:0] repeats = 8'd0;
  logic [3:0] gap     = 4'd0;
  logic       match;
  logic       en;
  logic [7:0] payload;
  logic       busy;
  logic       done;
  logic [7:0] match_count;
  logic       miss;
`ifdef NFA_GEN_CORRUPT_EN
  logic       corrupt = 1'b0;
`endif

  logic m_echo  = 1'b0;
  logic m_hold  = 1'b0;
  logic m_noise = 1'b0;
  assign match = m_echo | m_hold | m_noise;

  always #5 clk = ~clk;

  nfa_stream_gen dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .repeats     (repeats),
    .gap         (gap),
    .match       (match),
`ifdef NFA_GEN_CORRUPT_EN
    .corrupt     (corrupt),
`endif
    .en          (en),
    .payload     (payload),
    .busy        (busy),
    .done        (done),
    .match_count (match_count),
    .miss        (miss)
  );

  typedef struct { int cyc; logic [7:0] b; } exp_byte_t;
  typedef struct { int cyc; int mc_d; int miss_d; int mc_f; int miss_f; } exp_res_t;

  exp_byte_t byte_q[$];
  exp_res_t  res_q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int ncyc   = 0;

  bit cmask [256];
  bit echo_en    = 1'b1;
  bit drop_first = 1'b0;
  int a_seen     = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, ncyc);
    end
  endtask

  always @(posedge clk) ncyc <= ncyc + 1;

  // Monitor: compares every en byte and every done pulse against the scoreboard.
  bit       final_pending = 1'b0;
  exp_res_t fin;
  always @(negedge clk) begin
    if (reset_n) begin
      if (en) begin
        if (byte_q.size() == 0) begin
          check("en_unexpected", int'(en), 0);
        end else begin
          exp_byte_t e;
          e = byte_q.pop_front();
          check("byte_cycle", ncyc, e.cyc);
          check("byte_value", int'(payload), int'(e.b));
          check("busy_in_run", int'(busy), 1);
        end
      end
      if (done) begin
        if (res_q.size() == 0) begin
          check("done_unexpected", int'(done), 0);
        end else begin
          exp_res_t r;
          r = res_q.pop_front();
          check("done_cycle", ncyc, r.cyc);
          check("done_match_count", int'(match_count), r.mc_d);
          check("done_miss", int'(miss), r.miss_d);
          check("done_busy", int'(busy), 0);
          check("bytes_left_at_done", byte_q.size(), 0);
          fin = r;
          final_pending = 1'b1;
        end
      end else if (final_pending) begin
        final_pending = 1'b0;
        check("final_match_count", int'(match_count), fin.mc_f);
        check("final_miss", int'(miss), fin.miss_f);
      end
    end else begin
      final_pending = 1'b0;
    end
  end

  // Reference matcher: pulses match one cycle after seeing a,b,c on consecutive en cycles.
  logic [7:0] p1 = 8'h00;
  logic [7:0] p2 = 8'h00;
  bit         pend = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      p1 = 8'h00; p2 = 8'h00; pend = 1'b0; m_echo = 1'b0;
    end else begin
      m_echo = pend;
      pend   = 1'b0;
      if (en) begin
        if (payload == PAT2 && p1 == PAT1 && p2 == PAT0 && echo_en) begin
          if (drop_first) drop_first = 1'b0;
          else pend = 1'b1;
        end
        p2 = p1;
        p1 = payload;
      end else begin
        p1 = 8'h00; p2 = 8'h00;
      end
    end
  end

`ifdef NFA_GEN_CORRUPT_EN
  always @(negedge clk) begin
    if (reset_n && en && payload == PAT0 && a_seen < 256) begin
      corrupt = cmask[a_seen];
      a_seen++;
    end else begin
      corrupt = 1'b0;
    end
  end
`endif

  function automatic void push_bytes(input int n0, input int r, input int g);
    int idx;
    exp_byte_t e;
    idx = 0;
    for (int k = 0; k < r; k++) begin
      for (int i = 0; i < g; i++) begin
        e.cyc = n0 + 1 + idx; e.b = FILL; byte_q.push_back(e); idx++;
      end
      e.cyc = n0 + 1 + idx; e.b = PAT0; byte_q.push_back(e); idx++;
      e.cyc = n0 + 1 + idx; e.b = cmask[k] ? ~PAT1 : PAT1; byte_q.push_back(e); idx++;
      e.cyc = n0 + 1 + idx; e.b = PAT2; byte_q.push_back(e); idx++;
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    byte_q.delete();
    res_q.delete();
    @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  // mode: 0 matcher echoes, 1 match tied low, 2 first match dropped, 3 match held high
  task automatic run(input int r, input int g, input int mode);
    int n0, lat, corr, expv, mcd, mcf, pulse_j;
    bit got;
    exp_res_t rs;
    corr = 0;
    for (int k = 0; k < r; k++) corr += int'(cmask[k]);
    lat  = (r == 0) ? 1 : 1 + r * (g + 3) + DRAIN;
    expv = r - corr;
    case (mode)
      0:       mcd = expv;
      1:       mcd = 0;
      2:       mcd = (expv > 0) ? expv - 1 : 0;
      default: mcd = (lat - 1 > 255) ? 255 : lat - 1;
    endcase
    mcf = (mode == 3) ? ((lat > 255) ? 255 : lat) : mcd;
    rs.mc_d   = mcd;
    rs.miss_d = int'(mcd != expv);
    rs.mc_f   = mcf;
    rs.miss_f = int'((mcd != expv) || (mcf != expv));

    @(negedge clk);
    n0 = ncyc;
    rs.cyc = n0 + lat;
    push_bytes(n0, r, g);
    res_q.push_back(rs);
    echo_en    = (mode != 1);
    drop_first = (mode == 2);
    m_hold     = (mode == 3);
    a_seen     = 0;
    start   = 1'b1;
    repeats = 8'(r);
    gap     = 4'(g);
    pulse_j = ($urandom_range(0, 1) == 1) ? $urandom_range(1, lat) : 0;
    got = 1'b0;
    for (int j = 1; j <= lat + 20; j++) begin
      @(negedge clk);
      if (j == 1) begin
        check("start_clears_count", int'(match_count), 0);
        check("start_clears_miss", int'(miss), 0);
      end
      if (j == pulse_j) begin
        start = 1'b1; repeats = 8'($urandom); gap = 4'($urandom);
      end else begin
        start = 1'b0;
      end
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check("done_timeout", 0, 1);
      start = 1'b0;
      do_reset();
    end else begin
      @(negedge clk);
      start = 1'b0;
      check("idle_after_done_busy", int'(busy), 0);
      check("idle_after_done_en", int'(en), 0);
      m_hold = 1'b0;
      drop_first = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        m_noise = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      m_noise = 1'b0;
      @(negedge clk);
      check("idle_holds_count", int'(match_count), mcf);
      check("idle_holds_miss", int'(miss), rs.miss_f);
    end
    echo_en = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) cmask[k] = 1'b0;
    #12;
    check("rst_en", int'(en), 0);
    check("rst_payload", int'(payload), int'(FILL));
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_match_count", int'(match_count), 0);
    check("rst_miss", int'(miss), 0);
    @(negedge clk);
    #2 reset_n = 1'b1;

    run(2, 1, 0);
    run(3, 0, 0);
    run(0, 5, 0);
    run(2, 1, 1);
    run(2, 3, 0);
    run(0, 0, 3);
    run(1, 2, 2);

    // Asynchronous reset while the second pattern byte is on the bus.
    begin
      int n0;
      bit seen;
      exp_res_t rs;
      @(negedge clk);
      n0 = ncyc;
      push_bytes(n0, 2, 0);
      rs.cyc = n0 + 11; rs.mc_d = 2; rs.miss_d = 0; rs.mc_f = 2; rs.miss_f = 0;
      res_q.push_back(rs);
      start = 1'b1; repeats = 8'd2; gap = 4'd0;
      @(negedge clk);
      start = 1'b0;
      seen = 1'b0;
      for (int j = 0; j < 10; j++) begin
        if (en && payload == PAT1) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check("reach_second_byte", int'(seen), 1);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_en", int'(en), 0);
      check("async_rst_payload", int'(payload), int'(FILL));
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_done", int'(done), 0);
      byte_q.delete();
      res_q.delete();
      @(negedge clk);
      #2 reset_n = 1'b1;
      repeat (12) @(negedge clk);
      check("post_rst_busy", int'(busy), 0);
    end

    run(2, 1, 0);
`ifdef NFA_GEN_CORRUPT_EN
    cmask[0] = 1'b1;
    run(2, 0, 0);
    cmask[0] = 1'b0;
`endif
    run(255, 0, 0);
    run(90, 0, 3);

    for (int t = 0; t < 25; t++) begin
      int r, g, m;
      r = $urandom_range(0, 6);
      g = $urandom_range(0, 15);
      m = $urandom_range(0, 3);
`ifdef NFA_GEN_CORRUPT_EN
      for (int k = 0; k < 8; k++) cmask[k] = ($urandom_range(0, 2) == 0);
`endif
      run(r, g, m);
    end

    repeat (3) @(negedge clk);
    check("queues_empty", byte_q.size() + res_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nfa_stream_gen.md
Name: nfa_stream_gen

Overview:
- Byte-stream source that drives an NFA matcher chain through its en/payload interface. It is the transmit side of the matcher's payload interface.
- Emits a programmed 3-byte literal pattern a configurable number of times, with filler-byte gaps between repeats.
- Counts match pulses returned by the matcher under test and flags a mismatch between expected and observed matches.
- Sits in front of the matcher chain in test/bring-up harnesses and in loopback self-check.

Parameters:
PAT0, 8'h61, first pattern byte ('a')
PAT1, 8'h62, second pattern byte ('b')
PAT2, 8'h63, third pattern byte ('c')
FILL, 8'h78, filler byte emitted in gaps and when idle ('x')
CNT_W, 8, width of repeat counter and match counter
DRAIN_CYC, 4, cycles with en=0 after the last pattern byte, to absorb matcher latency

Ports:
clk  input  1  single clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle run request; sampled only in IDLE
repeats  input  CNT_W  number of pattern repetitions; latched on accepted start
gap  input  4  filler bytes before each repetition; latched on accepted start
match  input  1  match pulse from the matcher under test
en  output  1  payload-valid strobe to the matcher
payload  output  8  byte to the matcher
busy  output  1  high from the cycle after an accepted start until DONE
done  output  1  one-cycle completion pulse
match_count  output  CNT_W  matches observed during the run (saturating)
miss  output  1  sticky: match_count != expected at completion

Behaviour:
- Interface decided: one clock, clk; reset reset_n, asynchronous, active-low.
- Reset values: en=0, payload=FILL, busy=0, done=0, match_count=0, miss=0, FSM=IDLE, all internal counters 0.
- All outputs are registered. en and payload change together on the clock edge.
- FSM states: IDLE, GAP, PAT, DRAIN, DONE.
- IDLE:
  - en=0, payload=FILL.
  - On start=1: latch repeats and gap; clear match_count and miss.
  - If repeats==0, go to DONE.
  - Else if gap==0, go to PAT.
  - Else go to GAP.
- GAP:
  - Emit FILL with en=1 for exactly the latched gap cycles, then go to PAT.
- PAT:
  - Emit PAT0, PAT1, PAT2 on 3 consecutive cycles, en=1 on each.
  - After PAT2, decrement the remaining-repeat count.
  - If remaining > 0: go to GAP, or directly to PAT when gap==0, giving a back-to-back "abcabc".
  - Else go to DRAIN.
- DRAIN:
  - en=0, payload=FILL for DRAIN_CYC cycles, then go to DONE.
- DONE:
  - done=1 for one cycle; busy=0.
  - miss is set if match_count != expected (expected = latched repeats).
  - Return to IDLE.
- match_count:
  - Increments on every cycle with match=1 while busy, including DRAIN, and in the DONE cycle itself.
  - Saturates at 2^CNT_W-1.
  - Holds its value in IDLE until the next accepted start.
  - match=1 in IDLE is ignored.
- Boundary conditions:
  - start while busy is ignored.
  - start on the same cycle as done is ignored.
  - repeats==0 gives done exactly 1 cycle after start, no en activity, miss=0.
  - repeats = max value runs the full count; there is no wrap.
  - reset_n low mid-run returns everything to reset values immediately (asynchronous). There is no partial done.
- Latency: first en=1 byte appears 1 cycle after start is sampled.
  - Total run length = 1 + repeats*(gap+3) + DRAIN_CYC cycles to DONE.

Optional Feature:
NFA_GEN_CORRUPT_EN
- With the macro:
  - Adds input port corrupt (1 bit), sampled on the cycle PAT0 is emitted.
  - If corrupt=1, that repetition emits ~PAT1 in place of PAT1.
  - A corrupted-repeat counter is kept, and expected = repeats - corrupted.
- Without the macro: port absent, expected = repeats, and all logic tied off.

Test Plan:
- repeats=2, gap=1, matcher echoes correctly -> payload x,a,b,c,x,a,b,c, then 4 idle cycles; done once; match_count=2; miss=0.
- repeats=3, gap=0 -> a,b,c,a,b,c,a,b,c with en high for 9 consecutive cycles; match_count=3.
- repeats=0, start -> done 1 cycle later; en never high; miss=0.
- repeats=2, match tied low -> done; match_count=0; miss=1. Next start clears miss.
- reset_n pulled low during the second PAT byte -> en=0, payload=8'h78, busy=0 asynchronously; no done. A later start runs normally.
- NFA_GEN_CORRUPT_EN, repeats=2, corrupt=1 on the first repeat -> bytes a,8'h9d,c,a,b,c; expected=1; match_count=1; miss=0.
